// File: rtl/mips_pkg.sv
// Shared constants for the mips memory responder: default bus widths and
// the two-state LOAD/RUN encoding.
package mips_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // One-bit state register: LOAD holds the core in reset, RUN serves it.
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : mips_pkg

// File: rtl/mips_ram_1rw.sv
// Single-address synchronous RAM: one write port and a registered read
// port sharing the same address. A read that coincides with a write to
// the same location returns the new data (write-first).
module mips_ram_1rw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write on we; capture read data on re, holding it otherwise.
    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM and so contents survive a reset; nonblocking assignments keep
    // the write and the read of the same edge from racing each other.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= we ? wdata : mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : mips_ram_1rw

// File: rtl/mips_mem_responder.sv
// Memory end of the 8-bit multicycle mips core. After reset it accepts a
// program image over a valid/ready loader port while holding the core in
// reset, then serves core reads (1-cycle registered) and writes.
module mips_mem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = mips_pkg::ADDR_W,
    parameter int DATA_W    = mips_pkg::DATA_W,
    parameter bit SKIP_LOAD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [DATA_W-1:0] memdata,
    output logic              rd_valid,
    output logic              cpu_reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              err_collide
);

    localparam logic [0:0]    ST_RESET = SKIP_LOAD ? ST_RUN : ST_LOAD;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              rd_seen_q, rd_seen_d;

    logic              in_load;
    logic              ld_fire;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign in_load = (state_q == ST_LOAD);
    assign ld_fire = ld_valid & in_load;

    // Port mux: the loader owns the RAM in LOAD, the core owns it in RUN.
    assign ram_we    = in_load ? ld_fire : memwrite;
    assign ram_re    = ~in_load & memread;
    assign ram_addr  = in_load ? ld_addr : adr;
    assign ram_wdata = in_load ? ld_data : writedata;

    mips_ram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state logic: FSM, saturating load counter, read strobe, sticky error.
    // NOTE: every signal gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = ram_re;
        err_d      = err_q | (ram_re & memwrite);
        rd_seen_d  = rd_seen_q | ram_re;
        if (ld_fire) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (ld_last) begin
                state_d = ST_RUN;
            end
        end
    end

    // State registers; reset forces LOAD at once, which raises cpu_reset
    // asynchronously with reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    // The RAM read register has no reset; memdata reads as zero until the
    // first read after reset refreshes it.
    assign memdata     = rd_seen_q ? ram_rdata : '0;
    assign rd_valid    = rd_valid_q;
    assign cpu_reset   = in_load;
    assign ld_ready    = in_load;
    assign load_count  = cnt_q;
    assign err_collide = err_q;

endmodule : mips_mem_responder

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed scenarios followed by
// randomized load and run traffic, compared each cycle against a reference
// model of the memory, its mode and its counters.
module tb_mips_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adr, writedata, ld_addr, ld_data;
    logic       memread, memwrite, ld_valid, ld_last;
    logic [7:0] memdata;
    logic       rd_valid, cpu_reset, ld_ready, err_collide;
    logic [8:0] load_count;

    // Second instance built with the load phase skipped.
    logic [7:0] s_adr, s_writedata, s_ld_addr, s_ld_data;
    logic       s_memread, s_memwrite, s_ld_valid, s_ld_last;
    logic [7:0] s_memdata;
    logic       s_rd_valid, s_cpu_reset, s_ld_ready, s_err_collide;
    logic [8:0] s_load_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0] m_mem [256];
    bit         m_load;
    int         m_cnt;
    logic [7:0] m_md;
    bit         m_rv;
    bit         m_err;

    always #5 clk = ~clk;

    mips_mem_responder #(.ADDR_W(8), .DATA_W(8), .SKIP_LOAD(1'b0)) dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
        .memread(memread), .memwrite(memwrite), .memdata(memdata),
        .rd_valid(rd_valid), .cpu_reset(cpu_reset), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .load_count(load_count), .err_collide(err_collide)
    );

    mips_mem_responder #(.ADDR_W(8), .DATA_W(8), .SKIP_LOAD(1'b1)) dut_skip (
        .clk(clk), .reset(reset), .adr(s_adr), .writedata(s_writedata),
        .memread(s_memread), .memwrite(s_memwrite), .memdata(s_memdata),
        .rd_valid(s_rd_valid), .cpu_reset(s_cpu_reset), .ld_valid(s_ld_valid),
        .ld_addr(s_ld_addr), .ld_data(s_ld_data), .ld_last(s_ld_last),
        .ld_ready(s_ld_ready), .load_count(s_load_count), .err_collide(s_err_collide)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 1'b1;
        m_cnt  = 0;
        m_md   = 8'h00;
        m_rv   = 1'b0;
        m_err  = 1'b0;
    endtask

    // Apply the behavioural rules to the inputs present at the last edge.
    task automatic model_step();
        if (m_load) begin
            m_rv = 1'b0;
            if (ld_valid) begin
                m_mem[ld_addr] = ld_data;
                if (m_cnt < 256) m_cnt++;
                if (ld_last) m_load = 1'b0;
            end
        end else begin
            m_rv = memread;
            if (memwrite) m_mem[adr] = writedata;
            if (memread) m_md = m_mem[adr];
            if (memread && memwrite) m_err = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("memdata",     {24'h0, memdata},    {24'h0, m_md});
        check("rd_valid",    {31'h0, rd_valid},   {31'h0, m_rv});
        check("err_collide", {31'h0, err_collide},{31'h0, m_err});
        check("cpu_reset",   {31'h0, cpu_reset},  {31'h0, m_load});
        check("ld_ready",    {31'h0, ld_ready},   {31'h0, m_load});
        check("load_count",  {23'h0, load_count}, m_cnt);
    endtask

    // One clock: edge, settle, update model, compare.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic core(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        memread = rd; memwrite = wr; adr = a; writedata = wd;
    endtask

    task automatic ld(input bit v, input logic [7:0] a, input logic [7:0] d, input bit last);
        ld_valid = v; ld_addr = a; ld_data = d; ld_last = last;
    endtask

    task automatic idle_all();
        core(0, 0, 8'h00, 8'h00);
        ld(0, 8'h00, 8'h00, 0);
        s_memread = 0; s_memwrite = 0; s_adr = 0; s_writedata = 0;
        s_ld_valid = 0; s_ld_addr = 0; s_ld_data = 0; s_ld_last = 0;
    endtask

    task automatic do_reset();
        idle_all();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int hs;
        logic [7:0] b0, b1, b2, b3;
        reset = 1'b1;
        idle_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values of both instances.
        compare_all();
        check("rst_memdata",    {24'h0, memdata}, 32'h0);
        check("rst_load_count", {23'h0, load_count}, 32'h0);
        check("skip_cpu_reset", {31'h0, s_cpu_reset}, 32'h0);
        check("skip_ld_ready",  {31'h0, s_ld_ready}, 32'h0);

        // Load the 4-byte image, last on the 4th.
        b0 = 8'h20; b1 = 8'h08; b2 = 8'h43; b3 = 8'h00;
        ld(1, 8'd0, b0, 0); cyc();
        ld(1, 8'd1, b1, 0); cyc();
        ld(1, 8'd2, b2, 0); cyc();
        check("cpu_reset_before_last", {31'h0, cpu_reset}, 32'h1);
        ld(1, 8'd3, b3, 1); cyc();
        check("load4_count",     {23'h0, load_count}, 32'd4);
        check("load4_cpu_reset", {31'h0, cpu_reset}, 32'h0);
        check("load4_ld_ready",  {31'h0, ld_ready}, 32'h0);
        ld(0, 8'd0, 8'd0, 0);

        // Read of address 2, then an idle cycle.
        core(1, 0, 8'd2, 8'h00); cyc();
        check("rd2_data",  {24'h0, memdata}, 32'h43);
        check("rd2_valid", {31'h0, rd_valid}, 32'h1);
        core(0, 0, 8'd0, 8'h00); cyc();
        check("idle_valid", {31'h0, rd_valid}, 32'h0);
        check("idle_hold",  {24'h0, memdata}, 32'h43);

        // Read-after-write.
        core(0, 1, 8'd10, 8'h5A); cyc();
        core(1, 0, 8'd10, 8'h00); cyc();
        check("raw_data", {24'h0, memdata}, 32'h5A);

        // Collision: write-through and sticky error.
        core(1, 1, 8'd3, 8'h77); cyc();
        check("coll_data", {24'h0, memdata}, 32'h77);
        check("coll_err",  {31'h0, err_collide}, 32'h1);
        core(0, 0, 8'd0, 8'h00); cyc();
        check("coll_err_sticky", {31'h0, err_collide}, 32'h1);
        core(1, 0, 8'd3, 8'h00); cyc();
        check("coll_readback", {24'h0, memdata}, 32'h77);

        // Reset mid-run: cpu_reset rises without a clock edge.
        core(0, 0, 8'd0, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("async_ld_ready",  {31'h0, ld_ready}, 32'h1);
        check("async_count",     {23'h0, load_count}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all();

        // Single last byte, then check the RAM kept the old image.
        ld(1, 8'd0, 8'hFF, 1); cyc();
        check("reload_count", {23'h0, load_count}, 32'd1);
        ld(0, 8'd0, 8'd0, 0);
        core(1, 0, 8'd1, 8'h00); cyc();
        check("preserved_adr1", {24'h0, memdata}, 32'h08);
        core(1, 0, 8'd0, 8'h00); cyc();
        check("reloaded_adr0", {24'h0, memdata}, 32'hFF);
        core(0, 0, 8'd0, 8'h00);

        // SKIP_LOAD instance: core write, ignored loader byte, readback.
        s_memwrite = 1; s_adr = 8'h20; s_writedata = 8'h11; cyc();
        s_memwrite = 0;
        s_ld_valid = 1; s_ld_addr = 8'h20; s_ld_data = 8'hEE; s_ld_last = 1; cyc();
        s_ld_valid = 0; s_ld_last = 0;
        s_memread = 1; s_adr = 8'h20; cyc();
        s_memread = 0;
        check("skip_ld_ignored", {24'h0, s_memdata}, 32'h11);
        check("skip_count",      {23'h0, s_load_count}, 32'h0);
        check("skip_cpu_reset_run", {31'h0, s_cpu_reset}, 32'h0);

        // Randomized load: full sweep plus extra bytes to hit saturation,
        // with core traffic that must be ignored.
        do_reset();
        hs = 0;
        for (int i = 0; i < 2000 && hs < 300; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            core($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 8'($urandom));
            ld(v, (hs < 256) ? 8'(hs) : 8'($urandom), 8'($urandom), v && (hs == 299));
            cyc();
            if (v) hs++;
        end
        check("load_handshakes", hs, 32'd300);
        check("sat_count", {23'h0, load_count}, 32'd256);
        ld(0, 8'd0, 8'd0, 0);

        // Randomized run traffic with loader noise.
        for (int i = 0; i < 600; i++) begin
            core($urandom_range(0, 1), ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
            ld($urandom_range(0, 1), 8'($urandom), 8'($urandom), $urandom_range(0, 1));
            cyc();
        end

        idle_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound in case the run stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule : tb_mips_mem_responder
